// File: rtl/mips_bus_if.sv
// mips_bus_if: bridges CPU load/store requests onto a single-beat stalling memory bus
// Ports:
//   clk, reset                    clock and asynchronous active-high reset
//   req_valid/req_ready           CPU request handshake
//   req_write/addr/size/signed    access descriptor (size 0..3 = byte..dword)
//   req_wdata                     right-justified store data
//   rsp_valid/rsp_rdata/rsp_err   one-cycle completion with extended load data
//   busy                          transaction in flight
//   address/read/write            bus command, held while waitrequest is high
//   writedata/byteenable          lane-aligned store data and lane mask
//   waitrequest/readdata          slave stall and read data
module mips_bus_if #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0,
    localparam int NB = DATA_W / 8,
    localparam int LB = $clog2(NB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [31:0]       address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [DATA_W-1:0] writedata,
    output logic [NB-1:0]     byteenable,
    input  logic [DATA_W-1:0] readdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_n;
    logic wr_q, sg_q, accept, bad, tmo, sign;
    logic [1:0] sz_q;
    logic [LB-1:0] off_q;
    logic [31:0] cnt;
    logic [2:0] align;
    logic [7:0] mask;
    logic [6:0] nbits;
    logic [DATA_W-1:0] keep, sh, ld;
    always_comb begin
        accept  = req_valid && (state == IDLE);
        align   = (req_size == 2'd0) ? 3'd0 : (req_size == 2'd1) ? 3'd1 : (req_size == 2'd2) ? 3'd3 : 3'd7;
        mask    = (req_size == 2'd0) ? 8'h01 : (req_size == 2'd1) ? 8'h03 : (req_size == 2'd2) ? 8'h0F : 8'hFF;
        bad     = (|(req_addr[2:0] & align)) || (req_size == 2'd3 && DATA_W == 32);
        tmo     = (TIMEOUT != 0) && waitrequest && (cnt == 32'(TIMEOUT - 1));
        // keep masks the loaded width; a full-width access shifts it to all ones
        nbits   = 7'd8 << sz_q;
        keep    = ~({DATA_W{1'b1}} << nbits);
        sh      = readdata >> {off_q, 3'b000};
        // keep ^ (keep >> 1) isolates the sign bit position of the loaded width
        sign    = sg_q && |(sh & (keep ^ (keep >> 1)));
        ld      = (sh & keep) | (sign ? ~keep : '0);
        state_n = (state == IDLE) ? (accept ? (bad ? RESP : BUS) : IDLE)
                : (state == BUS)  ? ((!waitrequest || tmo) ? RESP : BUS) : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            sg_q       <= 1'b0;
            sz_q       <= 2'd0;
            off_q      <= '0;
            cnt        <= '0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= (state != BUS) ? '0 : (waitrequest && cnt != 32'(TIMEOUT)) ? cnt + 32'd1 : cnt;
            rsp_err   <= (accept && bad) || (state == BUS && tmo);
            rsp_rdata <= (state == BUS && !waitrequest && !wr_q) ? ld : '0;
            if (accept) begin
                wr_q       <= req_write;
                sg_q       <= req_signed;
                sz_q       <= req_size;
                off_q      <= req_addr[LB-1:0];
                address    <= {req_addr[31:LB], {LB{1'b0}}};
                byteenable <= NB'(mask) << req_addr[LB-1:0];
                writedata  <= req_wdata << {req_addr[LB-1:0], 3'b000};
            end
        end
    end
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign read      = (state == BUS) && !wr_q;
    assign write     = (state == BUS) && wr_q;
endmodule

// File: doc/mips_bus_if.md
MIPS_BUS_IF -- requirements
Module: mips_bus_if

Interface
REQ-001 Parameter DATA_W, default 32, bus data width in bits; legal values 32 and 64.
REQ-002 Parameter TIMEOUT, default 0, waitrequest cycles before abort; 0 disables the timeout.
REQ-003 Parameter derived: NB = DATA_W/8 byte lanes; LB = log2(NB) address offset bits.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  CPU access request.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64).
REQ-011 req_signed  in  1  sign-extend load result; 0 = zero-extend.
REQ-012 req_wdata  in  DATA_W  store data, right-justified.
REQ-013 rsp_valid  out  1  one-cycle completion pulse for every accepted request.
REQ-014 rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
REQ-015 rsp_err  out  1  qualifies rsp_valid: misaligned, illegal size, or timeout.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 address  out  32  bus address, low LB bits always 0.
REQ-018 read / write  out  1 each  bus strobes, never both high.
REQ-019 waitrequest  in  1  slave stall.
REQ-020 writedata  out  DATA_W  lane-aligned store data.
REQ-021 byteenable  out  NB  active lanes, little-endian.
REQ-022 readdata  in  DATA_W  slave read data.

Function
REQ-023 The FSM SHALL have states IDLE, BUS and RESP; req_ready = 1 only in IDLE.
REQ-024 IDLE, request accepted and legal -> BUS; IDLE, request accepted but misaligned/illegal -> RESP with rsp_err=1 and no bus cycle.
REQ-025 Misaligned: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0; size 3 with DATA_W=32 is illegal.
REQ-026 In BUS, read or write (per the latched req_write) SHALL be high, and address/writedata/byteenable SHALL be held constant until the edge at which waitrequest=0.
REQ-027 BUS -> RESP at the first edge with waitrequest=0; for loads, readdata is captured at that edge.
REQ-028 RESP SHALL assert rsp_valid for exactly one cycle, then -> IDLE; response latency is 1 cycle after bus completion, and a new request is acceptable on the following edge.
REQ-029 byteenable = size mask (1, 3, 0xF or 0xFF) shifted left by addr[LB-1:0]; writedata = req_wdata shifted left by 8*addr[LB-1:0].
REQ-030 Load data = captured readdata shifted right by 8*offset, truncated to the size, then sign- or zero-extended to DATA_W per req_signed; a dword load is passed through unchanged.
REQ-031 All request fields SHALL be latched at acceptance; input changes during BUS have no effect.
REQ-032 When TIMEOUT>0, a counter SHALL count BUS cycles with waitrequest=1; on reaching TIMEOUT, the strobe drops, state -> RESP, rsp_err=1 and rsp_rdata=0.
REQ-033 The counter SHALL clear on entry to BUS and SHALL saturate; with TIMEOUT=0, BUS waits indefinitely.

Reset
REQ-034 Reset SHALL force IDLE asynchronously: req_ready=1 and every other output 0 (address, writedata, byteenable, rsp_rdata, rsp_err, read, write, rsp_valid, busy).
REQ-035 Reset asserted during BUS SHALL drop read/write in the same cycle, discard the transaction and produce no rsp_valid.

Verification
REQ-036 DATA_W=32, signed byte load from 0x1003, readdata=0x80AABBCC, waitrequest held 3 cycles -> byteenable=1000, address=0x1000, read held 4 cycles, rsp_rdata=0xFFFFFF80, rsp_err=0.
REQ-037 DATA_W=32, half store 0x1234 to 0x2002 -> write=1, byteenable=1100, writedata=0x12340000, one rsp_valid with rsp_rdata=0.
REQ-038 Word load from 0x0006 -> no read strobe, rsp_valid with rsp_err=1 on the edge after acceptance.
REQ-039 TIMEOUT=4, waitrequest stuck high -> read high for 4 cycles, then rsp_err=1 and read=0; the next request is accepted normally.
REQ-040 DATA_W=64, unsigned word load from 0x104, readdata=0xDEADBEEF_00000000 -> byteenable=0xF0, rsp_rdata=0x00000000_DEADBEEF.
REQ-041 Reset pulsed mid-BUS -> read=0 immediately, no rsp_valid, req_ready=1 after release.
